// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_pkg
// Description : Shared codes for multicycle_datapath: ALU functions, immediate
//               modes, sequencer states and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_NOT  = 4'd4;
    localparam logic [3:0] c_ALU_NAND = 4'd5;
    localparam logic [3:0] c_ALU_NOR  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SRL  = 4'd8;
    localparam logic [3:0] c_ALU_SLL  = 4'd9;
    localparam logic [3:0] c_ALU_ROL  = 4'd10;
    localparam logic [3:0] c_ALU_ROR  = 4'd11;

    localparam logic [1:0] c_IMM_SEXT  = 2'b00;
    localparam logic [1:0] c_IMM_ZEXT  = 2'b01;
    localparam logic [1:0] c_IMM_SHL16 = 2'b10;
    localparam logic [1:0] c_IMM_SEXT2 = 2'b11;

    localparam int c_RS_LSB  = 21;
    localparam int c_RD_LSB  = 16;
    localparam int c_RT_LSB  = 11;
    localparam int c_IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : dp_regfile
// Description : Register file, two asynchronous read ports, one synchronous
//               write port; register 0 always reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_regfile #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [RF_AW-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RF_AW-1:0]  i_raddr_a,
    input  logic [RF_AW-1:0]  i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [0:(1<<RF_AW)-1];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath
// Description : Multicycle CPU datapath with stage sequencer and ready/valid
//               instruction/data memory ports. Define DP_PERF_CNT_EN to enable
//               the cycle_cnt / instr_cnt performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [31:0]       Instr,
    input  logic              pc_sel,
    input  logic              rf_wren,
    input  logic              rf_wrdata_sel,
    input  logic              rf_b_sel,
    input  logic              alu_rf_a_sel,
    input  logic              alu_bin_sel,
    input  logic [3:0]        alu_func,
    input  logic [1:0]        imm_mode,
    input  logic              mem_rden,
    input  logic              mem_wren,
    output logic              Zero,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              busy,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
);

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_alu_out, r_mdr;
    logic              r_zero, r_imem_req, r_dmem_req, r_dmem_we;

    logic [RF_AW-1:0]  w_rs, w_rd, w_rt;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_imm_sext, w_imm_zext, w_imm_ext;
    logic [DATA_W-1:0] w_alu_a, w_alu_b, w_alu_y;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_rf_wdata;
    logic              w_rf_we, w_retire;
    logic [ADDR_W-1:0] w_pc_plus4, w_imm_pc, w_pc_next;

    assign w_rs  = r_ir[c_RS_LSB +: RF_AW];
    assign w_rd  = r_ir[c_RD_LSB +: RF_AW];
    assign w_rt  = r_ir[c_RT_LSB +: RF_AW];
    assign w_imm = r_ir[c_IMM_LSB +: 16];

    assign w_imm_sext = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_imm_zext = {{(DATA_W-16){1'b0}}, w_imm};

    always_comb begin
        w_imm_ext = w_imm_sext;
        case (imm_mode)
            c_IMM_SEXT:  w_imm_ext = w_imm_sext;
            c_IMM_ZEXT:  w_imm_ext = w_imm_zext;
            c_IMM_SHL16: w_imm_ext = w_imm_zext << 16;
            c_IMM_SEXT2: w_imm_ext = w_imm_sext << 2;
            default:     w_imm_ext = w_imm_sext;
        endcase
    end

    assign w_alu_a = alu_rf_a_sel ? '0 : r_a;
    assign w_alu_b = alu_bin_sel ? w_imm_ext : r_b;

    // Single-operand ops (NOT, shifts, rotates) act on the A input only.
    always_comb begin
        w_alu_y = '0;
        case (alu_func)
            c_ALU_ADD:  w_alu_y = w_alu_a + w_alu_b;
            c_ALU_SUB:  w_alu_y = w_alu_a - w_alu_b;
            c_ALU_AND:  w_alu_y = w_alu_a & w_alu_b;
            c_ALU_OR:   w_alu_y = w_alu_a | w_alu_b;
            c_ALU_NOT:  w_alu_y = ~w_alu_a;
            c_ALU_NAND: w_alu_y = ~(w_alu_a & w_alu_b);
            c_ALU_NOR:  w_alu_y = ~(w_alu_a | w_alu_b);
            c_ALU_SRA:  w_alu_y = {w_alu_a[DATA_W-1], w_alu_a[DATA_W-1:1]};
            c_ALU_SRL:  w_alu_y = {1'b0, w_alu_a[DATA_W-1:1]};
            c_ALU_SLL:  w_alu_y = {w_alu_a[DATA_W-2:0], 1'b0};
            c_ALU_ROL:  w_alu_y = {w_alu_a[DATA_W-2:0], w_alu_a[DATA_W-1]};
            c_ALU_ROR:  w_alu_y = {w_alu_a[0], w_alu_a[DATA_W-1:1]};
            default:    w_alu_y = '0;
        endcase
    end

    assign w_pc_plus4 = r_pc + c_PC_STEP;
    assign w_imm_pc   = {{(ADDR_W-18){w_imm[15]}}, w_imm, 2'b00};
    assign w_pc_next  = pc_sel ? (w_pc_plus4 + w_imm_pc) : w_pc_plus4;

    assign w_retire = ((r_state == ST_EXEC) && !(mem_rden || mem_wren) && !rf_wren)
                   || ((r_state == ST_MEM) && dmem_ack && r_dmem_we)
                   || (r_state == ST_WB);

    // Writes are suppressed while Reset is asserted so an abandoned WB has no effect.
    assign w_rf_we    = (r_state == ST_WB) && rf_wren && !Reset;
    assign w_rf_wdata = rf_wrdata_sel ? r_mdr : r_alu_out;

    dp_regfile #(
        .DATA_W (DATA_W),
        .RF_AW  (RF_AW)
    ) u_regfile (
        .clk       (Clk),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b (rf_b_sel ? w_rd : w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_alu_out  <= '0;
            r_mdr      <= '0;
            r_zero     <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a     <= w_rf_a;
                    r_b     <= w_rf_b;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_alu_out <= w_alu_y;
                    r_zero    <= (w_alu_y == '0);
                    if (mem_rden || mem_wren) begin
                        r_state    <= ST_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= mem_wren;
                    end else if (rf_wren) begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (!r_dmem_we) begin
                            r_mdr   <= dmem_rdata;
                            r_state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_state <= ST_WB;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Retirement overrides the per-state next state.
            if (w_retire) begin
                r_pc       <= w_pc_next;
                r_state    <= ST_FETCH;
                r_imem_req <= 1'b1;
            end
        end
    end

    assign Instr      = r_ir;
    assign Zero       = r_zero;
    assign imem_req   = r_imem_req && !Reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req && !Reset;
    assign dmem_we    = r_dmem_we && !Reset;
    assign dmem_addr  = ADDR_W'(r_alu_out);
    assign dmem_wdata = r_a;
    assign busy       = (r_state != ST_IDLE);

`ifdef DP_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != ST_IDLE) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire)           r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_datapath
// Description : Directed self-checking bench for multicycle_datapath acting as
//               control unit plus instruction and data memories.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;
    import dp_pkg::*;

    localparam logic [7:0] c_AZ  = 8'h80;
    localparam logic [7:0] c_BI  = 8'h40;
    localparam logic [7:0] c_BRD = 8'h20;
    localparam logic [7:0] c_WR  = 8'h10;
    localparam logic [7:0] c_WS  = 8'h08;
    localparam logic [7:0] c_RD  = 8'h04;
    localparam logic [7:0] c_MW  = 8'h02;
    localparam logic [7:0] c_PS  = 8'h01;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  ctl;
        logic [3:0]  func;
        logic [1:0]  imode;
        int          fd;
        int          md;
        logic [31:0] ld;
        int          cyc;
        logic        z;
        logic [31:0] pc;
        logic [31:0] ma;
        logic [31:0] wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_o;
    logic        pc_sel = 0, rf_wren = 0, wr_sel = 0, b_sel = 0, a_sel = 0, bin_sel = 0;
    logic [3:0]  alu_func = '0;
    logic [1:0]  imm_mode = '0;
    logic        mem_rden = 0, mem_wren = 0;
    logic        zero;
    logic        imem_req, imem_ack = 0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        busy;
    logic [31:0] cycle_cnt, instr_cnt;

    int n_run  = 0;
    int n_fail = 0;

    vec_t tbl [28];
    vec_t br  [5];

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(32), .RF_AW(5), .ADDR_W(32)) dut (
        .Clk(clk), .Reset(rst), .Instr(instr_o),
        .pc_sel(pc_sel), .rf_wren(rf_wren), .rf_wrdata_sel(wr_sel), .rf_b_sel(b_sel),
        .alu_rf_a_sel(a_sel), .alu_bin_sel(bin_sel), .alu_func(alu_func), .imm_mode(imm_mode),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .Zero(zero),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .busy(busy),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    function automatic logic [31:0] ii(input int rs, input int rd, input logic [15:0] imm);
        return {6'd0, 5'(rs), 5'(rd), imm};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rd, input int rt);
        return {6'd0, 5'(rs), 5'(rd), 5'(rt), 11'd0};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [7:0] ctl,
                                input logic [3:0] f, input logic [1:0] im, input int fd,
                                input int md, input logic [31:0] ld, input int cyc,
                                input logic z, input logic [31:0] pc, input logic [31:0] ma,
                                input logic [31:0] wd);
        vec_t v;
        v.instr = instr; v.ctl = ctl; v.func = f; v.imode = im; v.fd = fd; v.md = md;
        v.ld = ld; v.cyc = cyc; v.z = z; v.pc = pc; v.ma = ma; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Entry: at a negedge with imem_req high. Exit: at the negedge where the next fetch request appears.
    task automatic do_vec(input vec_t v, input string nm);
        int          cyc, md;
        logic        seen, stable, mwe;
        logic [31:0] maddr, wdata, pc0;
        cyc = 0; md = 0; seen = 0; stable = 1; mwe = 0; maddr = '0; wdata = '0;
        pc0 = imem_addr;
        {a_sel, bin_sel, b_sel, rf_wren, wr_sel, mem_rden, mem_wren, pc_sel} = v.ctl;
        alu_func = v.func; imm_mode = v.imode; imem_rdata = v.instr; dmem_rdata = v.ld;
        for (int k = 0; k < v.fd; k++) begin
            @(negedge clk); cyc++;
            if (!imem_req || imem_addr != pc0) stable = 0;
        end
        imem_ack = 1'b1;
        @(negedge clk); cyc++;
        imem_ack = 1'b0;
        while (!imem_req && cyc < 40) begin
            if (dmem_req) begin
                if (!seen) begin
                    seen = 1; maddr = dmem_addr; wdata = dmem_wdata; mwe = dmem_we;
                end else if (dmem_addr != maddr || dmem_wdata != wdata || dmem_we != mwe) begin
                    stable = 0;
                end
                if (md == v.md) dmem_ack = 1'b1;
                md++;
            end
            @(negedge clk); cyc++;
            dmem_ack = 1'b0;
        end
        chk({nm, " next_fetch"}, imem_req, 1'b1);
        chk({nm, " cycles"}, 32'(cyc), 32'(v.cyc));
        chk({nm, " pc"}, imem_addr, v.pc);
        chk({nm, " zero"}, zero, v.z);
        chk({nm, " held"}, stable, 1'b1);
        if ((v.ctl & (c_RD | c_MW)) != 8'h00) begin
            chk({nm, " dmem_req_seen"}, seen, 1'b1);
            chk({nm, " dmem_addr"}, maddr, v.ma);
            chk({nm, " dmem_we"}, mwe, (v.ctl & c_MW) != 8'h00);
            if ((v.ctl & c_MW) != 8'h00) chk({nm, " dmem_wdata"}, wdata, v.wd);
        end else begin
            chk({nm, " no_dmem"}, seen, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(ii(0, 2, 16'd5),      c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd4,  0, 0);
        tbl[1]  = mk(ii(0, 3, 16'd7),      c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd8,  0, 0);
        tbl[2]  = mk(ii(0, 5, 16'h55),     c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_ZEXT, 0, 0, 0, 4, 0, 32'd12, 0, 0);
        tbl[3]  = mk(ii(0, 6, 16'h8001),   c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd16, 0, 0);
        tbl[4]  = mk(rr(2, 1, 3),          c_WR,           c_ALU_ADD, c_IMM_SEXT, 3, 0, 0, 7, 0, 32'd20, 0, 0);
        tbl[5]  = mk(ii(1, 0, 16'h30),     c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd24, 32'h30, 32'd12);
        tbl[6]  = mk(ii(5, 2, 16'h20),     c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 3, 0, 7, 0, 32'd28, 32'h20, 32'h55);
        tbl[7]  = mk(ii(0, 7, 16'h10),     c_AZ|c_BI|c_RD|c_WR|c_WS, c_ALU_ADD, c_IMM_SEXT, 0, 2,
                     32'hDEADBEEF, 7, 0, 32'd32, 32'h10, 0);
        tbl[8]  = mk(ii(7, 0, 16'h40),     c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd36, 32'h40, 32'hDEADBEEF);
        tbl[9]  = mk(rr(2, 0, 3),          c_MW, c_ALU_SUB,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd40, 32'hFFFFFFFE, 32'd5);
        tbl[10] = mk(rr(6, 0, 3),          c_MW, c_ALU_AND,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd44, 32'h00000001, 32'hFFFF8001);
        tbl[11] = mk(rr(6, 0, 3),          c_MW, c_ALU_OR,   c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd48, 32'hFFFF8007, 32'hFFFF8001);
        tbl[12] = mk(rr(6, 0, 3),          c_MW, c_ALU_NOT,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd52, 32'h00007FFE, 32'hFFFF8001);
        tbl[13] = mk(rr(6, 0, 3),          c_MW, c_ALU_NAND, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd56, 32'hFFFFFFFE, 32'hFFFF8001);
        tbl[14] = mk(rr(6, 0, 3),          c_MW, c_ALU_NOR,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd60, 32'h00007FF8, 32'hFFFF8001);
        tbl[15] = mk(rr(6, 0, 3),          c_MW, c_ALU_SRA,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd64, 32'hFFFFC000, 32'hFFFF8001);
        tbl[16] = mk(rr(6, 0, 3),          c_MW, c_ALU_SRL,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd68, 32'h7FFFC000, 32'hFFFF8001);
        tbl[17] = mk(rr(6, 0, 3),          c_MW, c_ALU_SLL,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd72, 32'hFFFF0002, 32'hFFFF8001);
        tbl[18] = mk(rr(6, 0, 3),          c_MW, c_ALU_ROL,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd76, 32'hFFFF0003, 32'hFFFF8001);
        tbl[19] = mk(rr(5, 0, 3),          c_MW, c_ALU_ROR,  c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd80, 32'h8000002A, 32'h55);
        tbl[20] = mk(rr(5, 0, 3),          c_MW, 4'hF,       c_IMM_SEXT, 0, 0, 0, 4, 1, 32'd84, 32'h0, 32'h55);
        tbl[21] = mk(ii(5, 0, 16'h1234),   c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SHL16, 0, 0, 0, 4, 0, 32'd88, 32'h12340000, 32'h55);
        tbl[22] = mk(ii(5, 0, 16'hFFFF),   c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SEXT2, 0, 0, 0, 4, 0, 32'd92, 32'hFFFFFFFC, 32'h55);
        tbl[23] = mk(ii(0, 0, 16'd9),      c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd96, 0, 0);
        tbl[24] = mk(ii(0, 0, 16'h44),     c_AZ|c_BI|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd100, 32'h44, 32'h0);
        tbl[25] = mk(ii(3, 0, 16'h50),     c_AZ|c_BI|c_RD|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd104, 32'h50, 32'd7);
        tbl[26] = mk(ii(2, 3, 16'h0),      c_BRD|c_MW, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd108, 32'd12, 32'd5);
        tbl[27] = mk(ii(0, 31, 16'd3),     c_AZ|c_BI|c_WR, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 4, 0, 32'd112, 0, 0);

        br[0] = mk(ii(31, 0, 16'hFFFE), c_PS, c_ALU_SUB, c_IMM_SEXT, 0, 0, 0, 3, 1, 32'hFFFFFFFC, 0, 0);
        br[1] = mk(ii(0, 0, 16'h0),     8'h00, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 3, 1, 32'h0, 0, 0);
        br[2] = mk(ii(0, 0, 16'h0),     8'h00, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 3, 1, 32'h4, 0, 0);
        br[3] = mk(ii(0, 0, 16'h0),     8'h00, c_ALU_ADD, c_IMM_SEXT, 0, 0, 0, 3, 1, 32'h8, 0, 0);
        br[4] = mk(ii(31, 0, 16'hFFFE), c_PS, c_ALU_SUB, c_IMM_SEXT, 0, 0, 0, 3, 1, 32'h4, 0, 0);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst imem_req", imem_req, 1'b0);
        chk("rst dmem_req", dmem_req, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst instr", instr_o, 32'h0);
        chk("rst zero", zero, 1'b0);
        chk("rst pc", imem_addr, 32'h0);

        // Reset abandons a fetch whose ack is withheld
        rst = 1'b0;
        @(negedge clk);
        chk("first fetch req", imem_req, 1'b1);
        chk("first fetch busy", busy, 1'b1);
        chk("first fetch addr", imem_addr, 32'h0);
        imem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("fetch held", imem_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midfetch rst req", imem_req, 1'b0);
        chk("midfetch rst busy", busy, 1'b0);
        chk("midfetch rst pc", imem_addr, 32'h0);
        chk("midfetch rst instr", instr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart req", imem_req, 1'b1);
        chk("restart addr", imem_addr, 32'h0);

        for (int i = 0; i < 28; i++) begin
            do_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Branch and PC wrap-around sequence from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        chk("rst2 req", imem_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2 restart addr", imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) begin
            do_vec(br[i], $sformatf("br%0d", i));
        end

`ifdef DP_PERF_CNT_EN
        chk("instr_cnt", instr_cnt, 32'd5);
        chk("cycle_cnt", cycle_cnt, 32'd15);
`else
        chk("instr_cnt tied", instr_cnt, 32'd0);
        chk("cycle_cnt tied", cycle_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multicycle successor to the team's single-cycle CPU datapath (fetch / decode / ALU / memory / write-back).
- Adds inter-stage registers (IR, A, B, ALUOut, MDR), an internal stage-sequencer FSM and ready/valid handshakes to external instruction and data memories, so memory latency can vary.
- An external control unit decodes the Instr output and drives the per-instruction control inputs. This block owns all sequencing.

Parameters:
- DATA_W, 32: datapath, register-file and memory data width.
- RF_AW, 5: register-file address width (2^RF_AW entries; R0 reads 0, writes ignored).
- ADDR_W, 32: PC and byte-address width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Instr  out  32  current IR: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], immed[15:0].
- pc_sel  in  1  0: PC+4; 1: PC+4+(Immed<<2). Sampled when the instruction retires.
- rf_wren, rf_wrdata_sel, rf_b_sel  in  1 each  RF write enable; write data select (0 ALUOut, 1 MDR); B address select (0 rt, 1 rd).
- alu_rf_a_sel, alu_bin_sel  in  1 each  A input (0 RF_A, 1 zero); B input (0 RF_B, 1 Immed).
- alu_func  in  4  ALU operation code (package codes).
- imm_mode  in  2  00 sign-extend, 01 zero-extend, 10 <<16, 11 sign-extend<<2.
- mem_rden, mem_wren  in  1 each  instruction performs a load / store.
- Zero  out  1  registered ALU zero flag.
- imem_req, imem_addr, imem_rdata, imem_ack  out/out/in/in  1/ADDR_W/32/1  instruction fetch handshake.
- dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_rdata, dmem_ack  out/out/out/out/in/in  1/1/ADDR_W/DATA_W/DATA_W/1  data memory handshake.
- busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset: state=IDLE, PC=0, IR=0, A=B=ALUOut=MDR=0, Zero=0. All req outputs 0, busy=0.
- IDLE→FETCH on the first cycle after Reset deasserts.
- FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack. On ack, IR<=imem_rdata and go to DECODE.
- DECODE: A<=RF[rs]; B<=RF[rf_b_sel?rd:rt]. Go to EXEC.
- EXEC: ALUOut<=ALU result; Zero<=(result==0).
  - mem_rden|mem_wren → MEM.
  - else rf_wren → WB.
  - else retire.
- MEM: dmem_req=1, dmem_addr=ALUOut, dmem_we=mem_wren, dmem_wdata=A (store source is the rs register). Requests are held until dmem_ack.
  - On ack, load: MDR<=dmem_rdata, then WB.
  - On ack, store: retire.
- WB: RF[rd]<=rf_wrdata_sel?MDR:ALUOut (skipped if rd==0), then retire.
- Retire: PC<=pc_sel ? PC+4+(Immed<<2) : PC+4, evaluated with the current Zero; next state FETCH.
- Latency per instruction:
  - ALU-only, no write: 3 + fetch wait.
  - ALU with write: 4 + fetch wait.
  - Load: 5 + fetch and data waits.
  - Store: 4 + fetch and data waits.
- ALU ops: ADD, SUB, AND, OR, NOT(A), NAND, NOR, SRA, SRL, SLL, ROL, ROR. Shifts and rotates are by 1. Results are modulo 2^DATA_W. Undefined codes give 0.
- Wrap-around: PC arithmetic is modulo 2^ADDR_W. 0xFFFF_FFFC+4 = 0.
- Reset mid-operation: abandons any pending handshake. req drops in the same cycle Reset is sampled. No RF or memory write occurs in that cycle.
- mem_rden and mem_wren both high: treated as a store.
- An ack without a req is ignored.

Optional Feature:
- DP_PERF_CNT_EN defined: 32-bit outputs cycle_cnt (increments every non-IDLE cycle) and instr_cnt (increments on each retire). Both clear on Reset and wrap at 2^32.
- Undefined: both ports present and tied to 0; no counter logic.

Decomposition:
- Package dp_pkg holds:
  - alu_func codes.
  - imm_mode codes.
  - FSM state enum.
  - Instruction field bit positions.
- Natural sub-module: dp_regfile (2 async read ports, 1 sync write port, R0 hardwired to 0).
- ALU and immediate logic stay inline.

Test Plan:
- Reset mid-FETCH with ack withheld → imem_req drops the cycle Reset is sampled; PC=0; busy=0; restart fetches address 0.
- ADD r1=r2+r3 with r2=5, r3=7, and imem_ack delayed 3 cycles → r1=12; instr retires 7 cycles after first imem_req; PC=4.
- Load with ALUOut=0x10, dmem_rdata=0xDEADBEEF, ack after 2 cycles → rd=0xDEADBEEF; dmem_we=0; addr stable during wait.
- Store r5=0x55 to 0x20 → dmem_we=1, dmem_wdata=0x55 held until ack; no RF write.
- Branch with PC=8, immed=0xFFFE, pc_sel=1, SUB equal operands → Zero=1; new PC=8+4-8=4.
- Write to R0 → R0 still reads 0; with DP_PERF_CNT_EN, instr_cnt=1 after retire.
